// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the PC, issues one-outstanding reads to instruction memory and buffers
// returned words with their PC for the IF/ID register.
// Optional feature macro: FETCH_BYPASS_EN (forward a live response straight to
// fetch_* when the buffer is empty and IF/ID is enabled).
module fetch_unit #(
  parameter int unsigned          D_WIDTH   = 32,
  parameter int unsigned          A_WIDTH   = 32,
  parameter logic [A_WIDTH-1:0]   RESET_PC  = 32'h00000000,
  parameter logic [D_WIDTH-1:0]   NOP_INSTR = 32'h00000013,
  parameter int unsigned          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [A_WIDTH-1:0] imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [D_WIDTH-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  input  logic               fetch_ready,
  output logic               fetch_valid,
  output logic [D_WIDTH-1:0] fetch_instr,
  output logic [A_WIDTH-1:0] fetch_pc
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] pc_q;
  logic [A_WIDTH-1:0] req_pc_q;
  logic [D_WIDTH-1:0] buf_instr_q [BUF_DEPTH];
  logic [A_WIDTH-1:0] buf_pc_q    [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic req_fire;
  logic rsp_live;
  logic buf_empty;
  logic bypass;
  logic push;
  logic pop;

  // Handshake and buffer control decode
  always_comb begin
    imem_req_valid = !rst && (state_q == ST_RUN) &&
                     (count_q < CNT_W'(BUF_DEPTH)) && !redirect_valid;
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response only counts while we are waiting for it and not flushing
    rsp_live       = (state_q == ST_WAIT) && imem_rsp_valid && !redirect_valid;
    buf_empty      = (count_q == '0);
`ifdef FETCH_BYPASS_EN
    bypass         = rsp_live && buf_empty && fetch_ready;
`else
    bypass         = 1'b0;
`endif
    push           = rsp_live && !bypass;
    pop            = !buf_empty && fetch_ready && !redirect_valid;
  end

  // Next-state logic for the one-outstanding request tracker
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (req_fire) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A same-cycle redirect drops the response but still closes the request
        if (imem_rsp_valid)      state_d = ST_RUN;
        else if (redirect_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (imem_rsp_valid) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output mux: bypassed response, buffer head, or NOP when nothing is valid
  always_comb begin
    fetch_valid = !buf_empty || bypass;
    fetch_instr = NOP_INSTR;
    fetch_pc    = '0;
    if (bypass) begin
      fetch_instr = imem_rsp_data;
      fetch_pc    = req_pc_q;
    end else if (!buf_empty) begin
      fetch_instr = buf_instr_q[rd_ptr_q];
      fetch_pc    = buf_pc_q[rd_ptr_q];
    end
  end

  // State, PC and buffer pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid)  pc_q <= redirect_pc;
      else if (req_fire)   pc_q <= pc_q + A_WIDTH'(4);
      if (req_fire) req_pc_q <= pc_q;
      if (redirect_valid) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Buffer storage; data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rsp_data;
      buf_pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (main instance plus a second
// instance with RESET_PC at the top of the address space for PC wrap).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        f_ready, f_valid;
  logic [31:0] f_instr, f_pc;

  logic        w_req_valid;
  logic        w_req_ready = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redir_valid = 1'b0;
  logic [31:0] w_redir_pc = '0;
  logic        w_f_ready = 1'b1;
  logic        w_f_valid;
  logic [31:0] w_f_instr, w_f_pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.D_WIDTH(32), .A_WIDTH(32), .RESET_PC(32'h00000000),
               .NOP_INSTR(32'h00000013), .BUF_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir_valid), .redirect_pc(redir_pc),
    .fetch_ready(f_ready), .fetch_valid(f_valid),
    .fetch_instr(f_instr), .fetch_pc(f_pc)
  );

  fetch_unit #(.D_WIDTH(32), .A_WIDTH(32), .RESET_PC(32'hFFFFFFFC),
               .NOP_INSTR(32'h00000013), .BUF_DEPTH(2)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redir_valid), .redirect_pc(w_redir_pc),
    .fetch_ready(w_f_ready), .fetch_valid(w_f_valid),
    .fetch_instr(w_f_instr), .fetch_pc(w_f_pc)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    redir_valid = 1'b0; redir_pc = '0; f_ready = 1'b0;
    w_rsp_valid = 1'b0; w_rsp_data = '0;

    // Reset held for two cycles
    tick; tick; settle;
    check("rst_req_valid", req_valid, 0);
    check("rst_fetch_valid", f_valid, 0);
    check("rst_fetch_instr", f_instr, 32'h00000013);
    check("rst_fetch_pc", f_pc, 0);

    // Release; main DUT holds its first request (ready=0), wrap DUT runs
    rst = 1'b0; settle;
    check("first_req_valid", req_valid, 1);
    check("first_req_addr", req_addr, 32'h00000000);
    check("wrap_req0_addr", w_req_addr, 32'hFFFFFFFC);
    tick;
    w_rsp_valid = 1'b1; w_rsp_data = mem(32'hFFFFFFFC); settle;
    check("wrap_wait_no_req", w_req_valid, 0);
    tick;
    w_rsp_valid = 1'b0; settle;
    check("wrap_req1_valid", w_req_valid, 1);
    check("wrap_req1_addr", w_req_addr, 32'h00000000);
    check("held_req_addr", req_addr, 32'h00000000);

    // Streaming with a 1-cycle memory
    req_ready = 1'b1; f_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle;
      check("strm_req_valid", req_valid, 1);
      check("strm_req_addr", req_addr, 32'(4 * k));
`ifdef FETCH_BYPASS_EN
      check("strm_req_cyc_fvalid", f_valid, 0);
`else
      if (k > 0) begin
        check("strm_fvalid", f_valid, 1);
        check("strm_fpc", f_pc, 32'(4 * (k - 1)));
        check("strm_finstr", f_instr, mem(32'(4 * (k - 1))));
      end else begin
        check("strm_first_fvalid", f_valid, 0);
      end
`endif
      tick;
      rsp_valid = 1'b1; rsp_data = mem(32'(4 * k)); settle;
      check("strm_wait_no_req", req_valid, 0);
`ifdef FETCH_BYPASS_EN
      check("byp_fvalid_same_cycle", f_valid, 1);
      check("byp_fpc", f_pc, 32'(4 * k));
      check("byp_finstr", f_instr, mem(32'(4 * k)));
`else
      check("buf_fvalid_not_same_cycle", f_valid, 0);
`endif
      tick;
      rsp_valid = 1'b0;
    end

    // Empty the buffer without issuing
    req_ready = 1'b0; settle;
`ifdef FETCH_BYPASS_EN
    check("drain_fvalid", f_valid, 0);
`else
    check("drain_fpc", f_pc, 32'h0000000C);
    check("drain_finstr", f_instr, mem(32'h0000000C));
`endif
    tick;

    // Stall: buffer fills to two, requests stop, head held
    f_ready = 1'b0; req_ready = 1'b1; settle;
    check("stall_req0_addr", req_addr, 32'h00000010);
    check("stall_fvalid0", f_valid, 0);
    tick;
    rsp_valid = 1'b1; rsp_data = mem(32'h10); settle;
    check("stall_no_bypass", f_valid, 0);
    tick;
    rsp_valid = 1'b0; settle;
    check("stall_fpc1", f_pc, 32'h00000010);
    check("stall_req1_addr", req_addr, 32'h00000014);
    check("stall_req1_valid", req_valid, 1);
    tick;
    rsp_valid = 1'b1; rsp_data = mem(32'h14); settle;
    tick;
    rsp_valid = 1'b0; settle;
    check("full_no_req_a", req_valid, 0);
    check("full_fpc_a", f_pc, 32'h00000010);
    tick; settle;
    check("full_no_req_b", req_valid, 0);
    check("full_fvalid_b", f_valid, 1);
    check("full_fpc_b", f_pc, 32'h00000010);
    tick;

    // Release stall: entries drain in order
    f_ready = 1'b1; settle;
    check("rel_fpc0", f_pc, 32'h00000010);
    check("rel_finstr0", f_instr, mem(32'h10));
    check("rel_full_no_req", req_valid, 0);
    tick;
    req_ready = 1'b0; settle;
    check("rel_fvalid1", f_valid, 1);
    check("rel_fpc1", f_pc, 32'h00000014);
    check("rel_finstr1", f_instr, mem(32'h14));
    check("rel_req_addr", req_addr, 32'h00000018);
    tick;
    req_ready = 1'b1; settle;
    check("rel_empty", f_valid, 0);
    check("pre_redir_req_addr", req_addr, 32'h00000018);
    tick;

    // Redirect while waiting: stale response discarded
    redir_valid = 1'b1; redir_pc = 32'h00000100; settle;
    check("redir_no_req", req_valid, 0);
    check("redir_fvalid", f_valid, 0);
    tick;
    redir_valid = 1'b0; rsp_valid = 1'b1; rsp_data = mem(32'h18); settle;
    check("drain_no_req", req_valid, 0);
    check("stale_not_fwd", f_valid, 0);
    tick;
    rsp_valid = 1'b0; settle;
    check("after_drain_req_valid", req_valid, 1);
    check("after_drain_req_addr", req_addr, 32'h00000100);
    check("stale_not_buffered", f_valid, 0);
    tick;
    rsp_valid = 1'b1; rsp_data = mem(32'h100); settle;
`ifdef FETCH_BYPASS_EN
    check("redir_byp_fpc", f_pc, 32'h00000100);
`else
    check("redir_rsp_cyc_fvalid", f_valid, 0);
`endif
    tick;
    rsp_valid = 1'b0; settle;
    check("req_104_addr", req_addr, 32'h00000104);
`ifndef FETCH_BYPASS_EN
    check("redir_first_fpc", f_pc, 32'h00000100);
    check("redir_first_finstr", f_instr, mem(32'h100));
`endif
    tick;

    // Redirect and response in the same cycle: response dropped
    redir_valid = 1'b1; redir_pc = 32'h00000200; rsp_valid = 1'b1; rsp_data = mem(32'h104); settle;
    check("redir_rsp_no_fwd", f_valid, 0);
    check("redir_rsp_no_req", req_valid, 0);
    tick;
    redir_valid = 1'b0; rsp_valid = 1'b0; settle;
    check("dropped_rsp_fvalid", f_valid, 0);
    check("req_200_addr", req_addr, 32'h00000200);
    check("req_200_valid", req_valid, 1);
    tick;

    // Redirect beats a same-cycle consume of a buffered entry
    f_ready = 1'b0; rsp_valid = 1'b1; rsp_data = mem(32'h200); settle;
    tick;
    rsp_valid = 1'b0; f_ready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h00000300; settle;
    check("pre_flush_fpc", f_pc, 32'h00000200);
    check("pre_flush_no_req", req_valid, 0);
    tick;
    redir_valid = 1'b0; settle;
    check("flush_fvalid", f_valid, 0);
    check("flush_finstr", f_instr, 32'h00000013);
    check("flush_fpc", f_pc, 0);
    check("req_300_addr", req_addr, 32'h00000300);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
